// File: rtl/time_set_ctrl.sv
// time_set_ctrl: automatic time-setting initiator for the lab clock.
// Drives the clock's manual button lines (Timeset, Minadv, Hrsadv, Dayadv)
// until the clock's readback matches the registered target.
// Optional feature macro: TSC_ALARM_SET_EN (adds alarm programming via mode,
// cur_amin, cur_ahrs and Alarmset).
module time_set_ctrl #(
    parameter int SETTLE   = 1,
    parameter int MAX_PASS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [6:0] tgt_min,
    input  logic [6:0] tgt_hrs,
    input  logic [6:0] tgt_day,
    input  logic [6:0] cur_min,
    input  logic [6:0] cur_hrs,
    input  logic [6:0] cur_day,
`ifdef TSC_ALARM_SET_EN
    input  logic       mode,
    input  logic [6:0] cur_amin,
    input  logic [6:0] cur_ahrs,
    output logic       Alarmset,
`endif
    output logic       Timeset,
    output logic       Minadv,
    output logic       Hrsadv,
    output logic       Dayadv,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_PULSE  = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_VERIFY = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam logic [1:0] F_MIN = 2'd0;
    localparam logic [1:0] F_HRS = 2'd1;
    localparam logic [1:0] F_DAY = 2'd2;

    localparam int CW = (SETTLE   > 1) ? $clog2(SETTLE)   : 1;
    localparam int PW = (MAX_PASS > 1) ? $clog2(MAX_PASS) : 1;

    logic [2:0]    r_state;
    logic [1:0]    r_fld;
    logic [PW-1:0] r_pass;
    logic [CW-1:0] r_cnt;
    logic [6:0]    r_tmin;
    logic [6:0]    r_thrs;
    logic [6:0]    r_tday;

    logic       w_alarm;     // registered mode of the operation in progress
    logic       w_mode_in;   // mode as presented with start
    logic [6:0] w_cmin;
    logic [6:0] w_chrs;
    logic       w_fld_eq;
    logic       w_last_fld;
    logic       w_all_eq;
    logic       w_tgt_ok;
    logic       w_active;

`ifdef TSC_ALARM_SET_EN
    logic r_mode;
    assign w_alarm   = r_mode;
    assign w_mode_in = mode;
    assign w_cmin    = r_mode ? cur_amin : cur_min;
    assign w_chrs    = r_mode ? cur_ahrs : cur_hrs;
`else
    assign w_alarm   = 1'b0;
    assign w_mode_in = 1'b0;
    assign w_cmin    = cur_min;
    assign w_chrs    = cur_hrs;
`endif

    // Field compare for CHECK, full compare for VERIFY, target range check for IDLE
    always_comb begin
        w_fld_eq = 1'b0;
        case (r_fld)
            F_MIN:   w_fld_eq = (w_cmin == r_tmin);
            F_HRS:   w_fld_eq = (w_chrs == r_thrs);
            default: w_fld_eq = (cur_day == r_tday);
        endcase
        // Alarm has no day field, so HRS is the last one there
        w_last_fld = w_alarm ? (r_fld == F_HRS) : (r_fld == F_DAY);
        w_all_eq   = (w_cmin == r_tmin) && (w_chrs == r_thrs) &&
                     (w_alarm || (cur_day == r_tday));
        w_tgt_ok   = (tgt_min <= 7'd59) && (tgt_hrs <= 7'd23) &&
                     (w_mode_in || (tgt_day <= 7'd6));
    end

    // Outputs decode straight from state so reset clears them without an edge
    assign w_active = (r_state == S_CHECK) || (r_state == S_PULSE) ||
                      (r_state == S_SETTLE) || (r_state == S_VERIFY);
    assign Timeset  = w_active & ~w_alarm;
`ifdef TSC_ALARM_SET_EN
    assign Alarmset = w_active & w_alarm;
`endif
    assign busy   = w_active;
    assign Minadv = (r_state == S_PULSE) && (r_fld == F_MIN);
    assign Hrsadv = (r_state == S_PULSE) && (r_fld == F_HRS);
    assign Dayadv = (r_state == S_PULSE) && (r_fld == F_DAY);
    assign done   = (r_state == S_DONE);
    assign err    = (r_state == S_ERR);

    // Control FSM: walk fields, pulse until each matches, then verify all
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_fld   <= F_MIN;
            r_pass  <= '0;
            r_cnt   <= '0;
            r_tmin  <= '0;
            r_thrs  <= '0;
            r_tday  <= '0;
`ifdef TSC_ALARM_SET_EN
            r_mode  <= 1'b0;
`endif
        end else if (abort) begin
            // abort outranks everything, including a coincident start in IDLE
            r_state <= S_IDLE;
            r_fld   <= F_MIN;
            r_pass  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_tgt_ok) begin
                            r_tmin  <= tgt_min;
                            r_thrs  <= tgt_hrs;
                            r_tday  <= tgt_day;
`ifdef TSC_ALARM_SET_EN
                            r_mode  <= mode;
`endif
                            r_fld   <= F_MIN;
                            r_pass  <= '0;
                            r_state <= S_CHECK;
                        end else begin
                            r_state <= S_ERR;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_fld_eq) begin
                        if (w_last_fld) r_state <= S_VERIFY;
                        else            r_fld   <= r_fld + 2'd1;
                    end else begin
                        r_state <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    r_cnt   <= '0;
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_cnt == CW'(SETTLE - 1)) r_state <= S_CHECK;
                    else                          r_cnt   <= r_cnt + 1'b1;
                end
                S_VERIFY: begin
                    // a carry may have disturbed an earlier field; retry from MIN
                    if (w_all_eq) begin
                        r_state <= S_DONE;
                    end else if (r_pass == PW'(MAX_PASS - 1)) begin
                        r_state <= S_ERR;
                    end else begin
                        r_pass  <= r_pass + 1'b1;
                        r_fld   <= F_MIN;
                        r_state <= S_CHECK;
                    end
                end
                default: r_state <= S_IDLE;   // DONE, ERR and unused codes
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: behavioural clock model closed in a loop with the DUT.
module tb_time_set_ctrl;

    logic       clk, rst, start, abort;
    logic [6:0] tgt_min, tgt_hrs, tgt_day;
    logic [6:0] m_min, m_hrs, m_day;
    logic       Timeset, Minadv, Hrsadv, Dayadv, busy, done, err;
    logic       setln;
`ifdef TSC_ALARM_SET_EN
    logic       mode, Alarmset;
    logic [6:0] a_min, a_hrs;
`endif

    int checks = 0;
    int errors = 0;

    // model control: ld presets the counters, cpl selects a coupling fault
    logic       ld;
    logic [6:0] ld_min, ld_hrs, ld_day;
    int         cpl;

    // event counters (free running, tests look at deltas)
    int n_min = 0, n_hrs = 0, n_day = 0, n_done = 0, n_err = 0, n_ts = 0, n_as = 0, n_viol = 0;

    time_set_ctrl #(.SETTLE(1), .MAX_PASS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .tgt_min(tgt_min), .tgt_hrs(tgt_hrs), .tgt_day(tgt_day),
        .cur_min(m_min), .cur_hrs(m_hrs), .cur_day(m_day),
`ifdef TSC_ALARM_SET_EN
        .mode(mode), .cur_amin(a_min), .cur_ahrs(a_hrs), .Alarmset(Alarmset),
`endif
        .Timeset(Timeset), .Minadv(Minadv), .Hrsadv(Hrsadv), .Dayadv(Dayadv),
        .busy(busy), .done(done), .err(err)
    );

`ifdef TSC_ALARM_SET_EN
    assign setln = Timeset | Alarmset;
`else
    assign setln = Timeset;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] inc(input logic [6:0] v, input int m);
        return (v == 7'(m - 1)) ? 7'd0 : v + 7'd1;
    endfunction

    // clock model: cpl 1 carries min->hrs on wrap, 2 Hrsadv also bumps min, 3 both ways always
    always @(posedge clk) begin
        if (ld) begin
            m_min <= ld_min; m_hrs <= ld_hrs; m_day <= ld_day;
`ifdef TSC_ALARM_SET_EN
            a_min <= 7'd0; a_hrs <= 7'd0;
`endif
        end else begin
            if (Timeset && Minadv) begin
                m_min <= inc(m_min, 60);
                if ((cpl == 1 && m_min == 7'd59) || cpl == 3) m_hrs <= inc(m_hrs, 24);
            end
            if (Timeset && Hrsadv) begin
                m_hrs <= inc(m_hrs, 24);
                if (cpl == 2 || cpl == 3) m_min <= inc(m_min, 60);
            end
            if (Timeset && Dayadv) m_day <= inc(m_day, 7);
`ifdef TSC_ALARM_SET_EN
            if (Alarmset && Minadv) a_min <= inc(a_min, 60);
            if (Alarmset && Hrsadv) a_hrs <= inc(a_hrs, 24);
`endif
        end
    end

    // protocol monitor and event counting
    always @(posedge clk) begin
        if (Minadv)  n_min  <= n_min + 1;
        if (Hrsadv)  n_hrs  <= n_hrs + 1;
        if (Dayadv)  n_day  <= n_day + 1;
        if (done)    n_done <= n_done + 1;
        if (err)     n_err  <= n_err + 1;
        if (Timeset) n_ts   <= n_ts + 1;
`ifdef TSC_ALARM_SET_EN
        if (Alarmset) n_as  <= n_as + 1;
        if (Timeset && Alarmset) n_viol <= n_viol + 1;
`endif
        if (((Minadv || Hrsadv || Dayadv) && !setln) ||
            (int'(Minadv) + int'(Hrsadv) + int'(Dayadv) > 1) ||
            (setln && !busy))
            n_viol <= n_viol + 1;
    end

    task automatic load(input logic [6:0] mi, input logic [6:0] hr, input logic [6:0] dy, input int c);
        @(negedge clk);
        ld_min = mi; ld_hrs = hr; ld_day = dy; cpl = c; ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
    endtask

    // one operation: cyc = edges from start sampling until done/err observed
    task automatic do_op(input logic [6:0] tm, input logic [6:0] th, input logic [6:0] td,
                         input int budget, output bit gd, output bit ge, output int cyc,
                         output bit b1, output bit endclean);
        @(negedge clk);
        tgt_min = tm; tgt_hrs = th; tgt_day = td; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tgt_min = 7'd0; tgt_hrs = 7'd0; tgt_day = 7'd0;   // must be ignored from now on
        b1 = busy && setln;
        cyc = 1;
        while (!done && !err && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        gd = done; ge = err;
        endclean = !setln && !busy;
    endtask

    task automatic test_reset();
        checks++;
        if ({Timeset, Minadv, Hrsadv, Dayadv, busy, done, err} !== 7'b0) begin
            errors++; $display("FAIL reset_outputs got %b exp 0000000", {Timeset, Minadv, Hrsadv, Dayadv, busy, done, err});
        end
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %b exp 0", busy); end
    endtask

    task automatic test_minutes();
        bit gd, ge, b1, ec; int cyc, bm, bh, bd, bdn, bv;
        load(7'd0, 7'd0, 7'd0, 0);
        bm = n_min; bh = n_hrs; bd = n_day; bdn = n_done; bv = n_viol;
        do_op(7'd5, 7'd0, 7'd0, 200, gd, ge, cyc, b1, ec);
        @(negedge clk);
        checks++; if (gd !== 1'b1 || ge !== 1'b0) begin errors++; $display("FAIL t1_done got done=%0d err=%0d exp 1 0", gd, ge); end
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL t1_busy_next got %0d exp 1", b1); end
        checks++; if (cyc != 20) begin errors++; $display("FAIL t1_latency got %0d exp 20", cyc); end
        checks++; if (n_min - bm != 5 || n_hrs != bh || n_day != bd) begin
            errors++; $display("FAIL t1_pulses got %0d/%0d/%0d exp 5/0/0", n_min - bm, n_hrs - bh, n_day - bd); end
        checks++; if (n_done - bdn != 1) begin errors++; $display("FAIL t1_done_count got %0d exp 1", n_done - bdn); end
        checks++; if (ec !== 1'b1 || n_viol != bv) begin errors++; $display("FAIL t1_protocol clean=%0d viol=%0d exp 1 0", ec, n_viol - bv); end
        checks++; if (m_min !== 7'd5) begin errors++; $display("FAIL t1_model_min got %0d exp 5", m_min); end
    endtask

    task automatic test_already_match();
        bit gd, ge, b1, ec; int cyc, bm;
        bm = n_min;
        do_op(7'd5, 7'd0, 7'd0, 50, gd, ge, cyc, b1, ec);
        checks++; if (gd !== 1'b1 || cyc != 5) begin errors++; $display("FAIL match_latency got done=%0d cyc=%0d exp 1 5", gd, cyc); end
        checks++; if (n_min != bm) begin errors++; $display("FAIL match_pulses got %0d exp 0", n_min - bm); end
    endtask

    task automatic test_wrap();
        bit gd, ge, b1, ec; int cyc, bm, bh, bd;
        load(7'd58, 7'd10, 7'd6, 0);
        bm = n_min; bh = n_hrs; bd = n_day;
        do_op(7'd2, 7'd11, 7'd0, 200, gd, ge, cyc, b1, ec);
        @(negedge clk);
        checks++; if (gd !== 1'b1) begin errors++; $display("FAIL t2_done got %0d exp 1", gd); end
        checks++; if (n_min - bm != 4 || n_hrs - bh != 1 || n_day - bd != 1) begin
            errors++; $display("FAIL t2_pulses got %0d/%0d/%0d exp 4/1/1", n_min - bm, n_hrs - bh, n_day - bd); end
        checks++; if ({m_min, m_hrs, m_day} !== {7'd2, 7'd11, 7'd0}) begin
            errors++; $display("FAIL t2_model got %0d:%0d d%0d exp 2:11 d0", m_hrs, m_min, m_day); end
    endtask

    task automatic test_invalid();
        bit gd, ge, b1, ec; int cyc, bm, bh, bd, bt;
        logic [6:0] vm [3] = '{7'd60, 7'd0, 7'd0};
        logic [6:0] vh [3] = '{7'd0, 7'd24, 7'd0};
        logic [6:0] vd [3] = '{7'd0, 7'd0, 7'd7};
        for (int i = 0; i < 3; i++) begin
            bm = n_min; bh = n_hrs; bd = n_day; bt = n_ts;
            do_op(vm[i], vh[i], vd[i], 20, gd, ge, cyc, b1, ec);
            @(negedge clk);
            checks++; if (ge !== 1'b1 || gd !== 1'b0 || cyc != 1) begin
                errors++; $display("FAIL t3_err[%0d] got err=%0d done=%0d cyc=%0d exp 1 0 1", i, ge, gd, cyc); end
            checks++; if (n_ts != bt || n_min != bm || n_hrs != bh || n_day != bd) begin
                errors++; $display("FAIL t3_quiet[%0d] got ts=%0d adv=%0d exp 0 0", i, n_ts - bt, n_min - bm + n_hrs - bh + n_day - bd); end
        end
    endtask

    task automatic test_verify();
        bit gd, ge, b1, ec; int cyc, bm, bh;
        // minute wrap carries into hours; HRS check repairs it in the same pass
        load(7'd59, 7'd22, 7'd0, 1);
        bm = n_min; bh = n_hrs;
        do_op(7'd0, 7'd22, 7'd0, 500, gd, ge, cyc, b1, ec);
        @(negedge clk);
        checks++; if (gd !== 1'b1 || n_min - bm != 1 || n_hrs - bh != 23) begin
            errors++; $display("FAIL t4_carry got done=%0d min=%0d hrs=%0d exp 1 1 23", gd, n_min - bm, n_hrs - bh); end
        // Hrsadv disturbs minutes; VERIFY catches it and pass 2 fixes it
        load(7'd0, 7'd5, 7'd0, 2);
        bm = n_min; bh = n_hrs;
        do_op(7'd0, 7'd6, 7'd0, 500, gd, ge, cyc, b1, ec);
        @(negedge clk);
        checks++; if (gd !== 1'b1 || n_min - bm != 59 || n_hrs - bh != 1) begin
            errors++; $display("FAIL t4_pass2 got done=%0d min=%0d hrs=%0d exp 1 59 1", gd, n_min - bm, n_hrs - bh); end
        // fields disturb each other every step: never settles, err after 3 passes
        load(7'd0, 7'd0, 7'd0, 3);
        bm = n_min; bh = n_hrs;
        do_op(7'd1, 7'd0, 7'd0, 2000, gd, ge, cyc, b1, ec);
        @(negedge clk);
        checks++; if (ge !== 1'b1 || gd !== 1'b0) begin errors++; $display("FAIL t4_stuck got err=%0d done=%0d exp 1 0", ge, gd); end
        checks++; if (n_min - bm != 87 || n_hrs - bh != 57) begin
            errors++; $display("FAIL t4_stuck_pulses got %0d/%0d exp 87/57", n_min - bm, n_hrs - bh); end
    endtask

    task automatic test_abort();
        bit gd, ge, b1, ec; int cyc, bm, bdn, k;
        load(7'd0, 7'd0, 7'd0, 0);
        bm = n_min; bdn = n_done;
        @(negedge clk); tgt_min = 7'd5; tgt_hrs = 7'd0; tgt_day = 7'd0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0;
        while (!(Minadv && n_min - bm == 2) && k < 100) begin @(negedge clk); k++; end
        checks++; if (k >= 100) begin errors++; $display("FAIL t5_wait_3rd got timeout exp Minadv"); end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checks++; if ({Timeset, Minadv, busy, done, err} !== 5'b0) begin
            errors++; $display("FAIL t5_abort_out got %b exp 00000", {Timeset, Minadv, busy, done, err}); end
        repeat (20) @(negedge clk);
        checks++; if (n_done != bdn || n_min - bm != 3 || m_min !== 7'd3) begin
            errors++; $display("FAIL t5_abort_after got done=%0d pulses=%0d min=%0d exp 0 3 3", n_done - bdn, n_min - bm, m_min); end
        // start together with abort in IDLE is dropped
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0 || Timeset !== 1'b0) begin errors++; $display("FAIL t5_start_abort got busy=%0d exp 0", busy); end
        // reset mid-PULSE clears outputs without a clock edge
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0;
        while (!Minadv && k < 20) begin @(negedge clk); k++; end
        #2 rst = 1'b0;
        #1;
        checks++; if ({Timeset, Minadv, busy, done, err} !== 5'b0 || k >= 20) begin
            errors++; $display("FAIL t5_rst_async got %b k=%0d exp 00000", {Timeset, Minadv, busy, done, err}, k); end
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (n_done != bdn) begin errors++; $display("FAIL t5_no_done got %0d exp 0", n_done - bdn); end
        // a normal operation still completes afterwards
        load(7'd0, 7'd0, 7'd0, 0);
        bm = n_min;
        do_op(7'd5, 7'd0, 7'd0, 200, gd, ge, cyc, b1, ec);
        @(negedge clk);
        checks++; if (gd !== 1'b1 || n_min - bm != 5 || m_min !== 7'd5) begin
            errors++; $display("FAIL t5_recover got done=%0d pulses=%0d min=%0d exp 1 5 5", gd, n_min - bm, m_min); end
    endtask

`ifdef TSC_ALARM_SET_EN
    task automatic test_alarm();
        bit gd, ge, b1, ec; int cyc, bm, bh, bt, ba, bv;
        load(7'd0, 7'd0, 7'd0, 0);
        bm = n_min; bh = n_hrs; bt = n_ts; ba = n_as; bv = n_viol;
        mode = 1'b1;
        do_op(7'd30, 7'd6, 7'd9, 500, gd, ge, cyc, b1, ec);
        mode = 1'b0;
        @(negedge clk);
        checks++; if (gd !== 1'b1 || n_min - bm != 30 || n_hrs - bh != 6) begin
            errors++; $display("FAIL t6_alarm got done=%0d min=%0d hrs=%0d exp 1 30 6", gd, n_min - bm, n_hrs - bh); end
        checks++; if (n_ts != bt || n_as == ba || n_viol != bv) begin
            errors++; $display("FAIL t6_lines got ts=%0d as=%0d viol=%0d exp 0 >0 0", n_ts - bt, n_as - ba, n_viol - bv); end
        checks++; if ({a_min, a_hrs, m_min, m_hrs} !== {7'd30, 7'd6, 7'd0, 7'd0}) begin
            errors++; $display("FAIL t6_model got a=%0d:%0d t=%0d:%0d exp 6:30 0:0", a_hrs, a_min, m_hrs, m_min); end
    endtask
`endif

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; ld = 1'b0; cpl = 0;
        tgt_min = 7'd0; tgt_hrs = 7'd0; tgt_day = 7'd0;
        ld_min = 7'd0; ld_hrs = 7'd0; ld_day = 7'd0;
`ifdef TSC_ALARM_SET_EN
        mode = 1'b0;
`endif
        #3;
        test_reset();
        test_minutes();
        test_already_match();
        test_wrap();
        test_invalid();
        test_verify();
        test_abort();
`ifdef TSC_ALARM_SET_EN
        test_alarm();
`endif
        checks++; if (n_viol != 0) begin errors++; $display("FAIL protocol_total got %0d exp 0", n_viol); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
